// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants, request kind / ALU codes and error causes.
// The instruction decoder uses the same definitions.
package riscv_pkg;

    localparam logic [2:0] KIND_LW   = 3'd0;
    localparam logic [2:0] KIND_SW   = 3'd1;
    localparam logic [2:0] KIND_R    = 3'd2;
    localparam logic [2:0] KIND_BEQ  = 3'd3;
    localparam logic [2:0] KIND_IALU = 3'd4;
    localparam logic [2:0] KIND_JAL  = 3'd5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_KIND = 2'b01,
        ERR_ALU  = 2'b10,
        ERR_IMM  = 2'b11
    } err_e;

    function automatic logic imm_fits(input logic [31:0] imm, input int lo, input int hi);
        return ($signed(imm) >= lo) && ($signed(imm) <= hi);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packing and legality check for one request.
// Cause priority: bad kind, then bad ALU code, then immediate range.
module instr_pack
    import riscv_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [2:0]  alu,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal,
    output logic [1:0]  cause
);

    logic [2:0] f3;
    logic [6:0] f7;
    logic       alu_ok;
    logic       imm_ok;
    err_e       cause_e;

    always_comb begin
        f3     = F3_ADD;
        f7     = F7_ZERO;
        alu_ok = 1'b1;
        case (alu)
            ALU_ADD: f3 = F3_ADD;
            ALU_SUB: begin
                f7     = F7_SUB;
                alu_ok = (kind != KIND_IALU);
            end
            ALU_AND: f3 = F3_AND;
            ALU_OR:  f3 = F3_OR;
            ALU_SLT: f3 = F3_SLT;
            default: alu_ok = 1'b0;
        endcase
    end

    always_comb begin
        word   = '0;
        imm_ok = 1'b1;
        case (kind)
            KIND_LW: begin
                word   = {imm[11:0], rs1, F3_WORD, rd, OP_LOAD};
                imm_ok = imm_fits(imm, -2048, 2047);
            end
            KIND_SW: begin
                word   = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OP_STORE};
                imm_ok = imm_fits(imm, -2048, 2047);
            end
            KIND_R: word = {f7, rs2, rs1, f3, rd, OP_OP};
            KIND_BEQ: begin
                word   = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BRANCH};
                imm_ok = imm_fits(imm, -4096, 4094) && !imm[0];
            end
            KIND_IALU: begin
                word   = {imm[11:0], rs1, f3, rd, OP_OPIMM};
                imm_ok = imm_fits(imm, -2048, 2047);
            end
            KIND_JAL: begin
                word   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
                imm_ok = imm_fits(imm, -1048576, 1048574) && !imm[0];
            end
            default: word = '0;
        endcase
    end

    always_comb begin
        cause_e = ERR_NONE;
        if (kind > KIND_JAL)
            cause_e = ERR_KIND;
        else if ((kind == KIND_R || kind == KIND_IALU) && !alu_ok)
            cause_e = ERR_ALU;
        else if (!imm_ok)
            cause_e = ERR_IMM;
    end

    assign cause   = cause_e;
    assign illegal = (cause_e != ERR_NONE);

endmodule

// File: rtl/instr_encoder.sv
// Streams encoded RV32I words to instruction memory addresses through a single
// output register; tracks write pointer, emitted count and first error cause.
module instr_encoder
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_kind,
    input  logic [2:0]  in_alu,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    input  logic        base_load,
    input  logic [31:0] base_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [15:0] count
);

    logic [31:0] word;
    logic        illegal;
    logic [1:0]  cause;
    logic [31:0] ptr;
    logic [31:0] ptr_use;
    logic        accept;
    logic        emit;

    instr_pack u_pack (
        .kind    (in_kind),
        .alu     (in_alu),
        .rd      (in_rd),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .imm     (in_imm),
        .word    (word),
        .illegal (illegal),
        .cause   (cause)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign emit     = accept && !illegal;
    // A base load in the same cycle as an accept places that word at base_addr.
    assign ptr_use  = base_load ? base_addr : ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= '0;
            ptr       <= '0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            count     <= '0;
        end else begin
            if (emit) begin
                out_valid <= 1'b1;
                out_instr <= word;
                out_addr  <= ptr_use;
                ptr       <= ptr_use + 32'd4;
                if (count != 16'hFFFF)
                    count <= count + 16'd1;
            end else begin
                if (base_load)
                    ptr <= base_addr;
                if (out_ready)
                    out_valid <= 1'b0;
            end
            if (accept && illegal) begin
                err <= 1'b1;
                if (!err)
                    err_code <= cause;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed scenarios plus randomized requests
// checked against an arithmetic reference model of the RV32I encodings.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_kind;
    logic [2:0]  in_alu;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        base_load;
    logic [31:0] base_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] count;

    instr_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_alu    (in_alu),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .base_load (base_load),
        .base_addr (base_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err       (err),
        .err_code  (err_code),
        .count     (count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];
    logic [63:0] mon_e;
    logic [31:0] ptr_m  = 0;
    int          cnt_m  = 0;
    logic        err_m  = 0;
    logic [1:0]  code_m = 0;
    bit          rdy_rand = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: legality from integer ranges, word from shifted fields.
    function automatic void model(input int kind, input int alu, input int rd, input int rs1,
                                  input int rs2, input logic [31:0] imm,
                                  output logic [1:0] code, output logic [31:0] word);
        longint      v = longint'($signed(imm));
        logic [31:0] d = rd, s1 = rs1, s2 = rs2, im = imm, f3 = 0, f7 = 0;
        bit          ok_alu = 1, ok_imm = 1;
        case (alu)
            0: f3 = 0;
            1: begin f7 = 32; ok_alu = (kind == 2); end
            2: f3 = 7;
            3: f3 = 6;
            5: f3 = 2;
            default: ok_alu = 0;
        endcase
        case (kind)
            0, 1, 4: ok_imm = (v >= -2048) && (v <= 2047);
            3:       ok_imm = (v >= -4096) && (v <= 4094) && (v % 2 == 0);
            5:       ok_imm = (v >= -1048576) && (v <= 1048574) && (v % 2 == 0);
            default: ok_imm = 1;
        endcase
        if (kind > 5)                               code = 2'd1;
        else if ((kind == 2 || kind == 4) && !ok_alu) code = 2'd2;
        else if (!ok_imm)                           code = 2'd3;
        else                                        code = 2'd0;
        case (kind)
            0: word = ((im & 32'hFFF) << 20) | (s1 << 15) | (32'd2 << 12) | (d << 7) | 32'h03;
            1: word = (((im >> 5) & 32'h7F) << 25) | (s2 << 20) | (s1 << 15) | (32'd2 << 12)
                      | ((im & 32'h1F) << 7) | 32'h23;
            2: word = (f7 << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | 32'h33;
            3: word = (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | (s2 << 20)
                      | (s1 << 15) | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 1) << 7) | 32'h63;
            4: word = ((im & 32'hFFF) << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | 32'h13;
            default: word = (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                      | (((im >> 11) & 1) << 20) | (((im >> 12) & 32'hFF) << 12) | (d << 7) | 32'h6F;
        endcase
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the request is accepted.
    task automatic issue(input int kind, input int alu, input int rd, input int rs1, input int rs2,
                         input logic [31:0] imm, input bit bl = 0, input logic [31:0] ba = 0);
        logic [1:0]  code;
        logic [31:0] word, addr;
        int          waited = 0;
        in_valid  = 1;
        in_kind   = kind[2:0];
        in_alu    = alu[2:0];
        in_rd     = rd[4:0];
        in_rs1    = rs1[4:0];
        in_rs2    = rs2[4:0];
        in_imm    = imm;
        base_load = bl;
        base_addr = ba;
        @(negedge clk);
        check("count", {16'b0, count}, cnt_m);
        check("err", {31'b0, err}, {31'b0, err_m});
        check("err_code", {30'b0, err_code}, {30'b0, code_m});
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1");
        end else begin
            model(kind, alu, rd, rs1, rs2, imm, code, word);
            if (code == 2'd0) begin
                addr = bl ? ba : ptr_m;
                exp_q.push_back({word, addr});
                ptr_m = addr + 32'd4;
                if (cnt_m < 65535) cnt_m++;
            end else begin
                if (!err_m) code_m = code;
                err_m = 1;
                if (bl) ptr_m = ba;
            end
        end
        sync();
        in_valid  = 0;
        base_load = 0;
        in_kind   = 3'($urandom);
        in_alu    = 3'($urandom);
        in_rd     = 5'($urandom);
        in_rs1    = 5'($urandom);
        in_rs2    = 5'($urandom);
        in_imm    = $urandom;
        base_addr = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            sync();
            n++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    task automatic reset_dut();
        rst_n = 0;
        #2;
        exp_q.delete();
        ptr_m  = 0;
        cnt_m  = 0;
        err_m  = 0;
        code_m = 0;
        rst_n  = 1;
        sync();
    endtask

    task automatic check_obs(input int idx, input logic [31:0] instr, input logic [31:0] addr);
        if (obs_q.size() <= idx) begin
            n_checks++;
            n_fail++;
            $display("FAIL obs_missing: got %0d words expected more than %0d", obs_q.size(), idx);
        end else begin
            check("obs_instr", obs_q[idx][63:32], instr);
            check("obs_addr", obs_q[idx][31:0], addr);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            obs_q.push_back({out_instr, out_addr});
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %h at %h expected none", out_instr, out_addr);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_instr", out_instr, mon_e[63:32]);
                check("out_addr", out_addr, mon_e[31:0]);
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        forever begin
            if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
            sync();
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a_first;
        int          boundary[14] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096,
                                      -4098, 1048574, -1048576, 1048576, -1048578, 1048575};
        rst_n = 0; in_valid = 0; in_kind = 0; in_alu = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0;
        in_imm = 0; base_load = 0; base_addr = 0; out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_in_ready", {31'b0, in_ready}, 1);
        check("rst_count", {16'b0, count}, 0);
        check("rst_err", {31'b0, err}, 0);
        check("rst_err_code", {30'b0, err_code}, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_instr", out_instr, 0);
        sync();

        // R add after reset
        issue(2, 0, 3, 1, 2, 0);
        @(negedge clk);
        check("radd_instr", out_instr, 32'h002081B3);
        check("radd_addr", out_addr, 32'h0);
        check("radd_count", {16'b0, count}, 1);
        sync();
        drain();

        // back-to-back sub then lw
        reset_dut();
        obs_q.delete();
        issue(2, 1, 5, 6, 7, 0);
        issue(0, 0, 2, 1, 0, -32'sd4);
        drain();
        check_obs(0, 32'h407302B3, 32'h0);
        check_obs(1, 32'hFFC0A103, 32'h4);

        // base load together with beq, then jal
        obs_q.delete();
        issue(3, 0, 0, 1, 2, 32'd8, 1, 32'h100);
        issue(5, 0, 1, 0, 0, 32'd2048);
        drain();
        check_obs(0, 32'h00208463, 32'h100);
        check_obs(1, 32'h001000EF, 32'h104);

        // illegal immediate, then a later error must not overwrite the cause
        issue(4, 0, 1, 1, 0, 32'd2048);
        @(negedge clk);
        check("ill_out_valid", {31'b0, out_valid}, 0);
        check("ill_err", {31'b0, err}, 1);
        check("ill_err_code", {30'b0, err_code}, 2'b11);
        sync();
        issue(4, 1, 1, 1, 0, 0);
        @(negedge clk);
        check("ill2_err_code", {30'b0, err_code}, 2'b11);
        sync();

        // backpressure: held word stays put, queued request goes when out_ready rises
        out_ready = 0;
        a_first = ptr_m;
        issue(2, 0, 3, 1, 2, 0);
        fork
            issue(0, 0, 4, 5, 0, 32'd16);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("hold_valid", {31'b0, out_valid}, 1);
                    check("hold_in_ready", {31'b0, in_ready}, 0);
                    check("hold_instr", out_instr, 32'h002081B3);
                    check("hold_addr", out_addr, a_first);
                end
                sync();
                out_ready = 1;
            end
        join
        @(negedge clk);
        check("queued_valid", {31'b0, out_valid}, 1);
        check("queued_instr", out_instr, 32'h0102A203);
        check("queued_addr", out_addr, a_first + 32'd4);
        sync();
        drain();

        // reset while a word is held
        out_ready = 0;
        issue(2, 2, 1, 1, 1, 0);
        rst_n = 0;
        #1;
        check("arst_out_valid", {31'b0, out_valid}, 0);
        check("arst_count", {16'b0, count}, 0);
        check("arst_err", {31'b0, err}, 0);
        exp_q.delete();
        ptr_m = 0; cnt_m = 0; err_m = 0; code_m = 0;
        #1;
        rst_n = 1;
        sync();
        out_ready = 1;
        obs_q.delete();
        issue(2, 3, 8, 9, 10, 0);
        drain();
        check_obs(0, 32'h00A4E433, 32'h0);

        // randomized traffic with random backpressure
        rdy_rand = 1;
        for (int n = 0; n < 400; n++) begin
            int          r, kind, alu, sel, t;
            logic [31:0] imm, ba;
            bit          bl;
            r    = $urandom_range(0, 9);
            kind = (r < 8) ? (r % 6) : (6 + r % 2);
            if ($urandom_range(0, 3) == 0) alu = $urandom_range(0, 7);
            else begin
                t   = $urandom_range(0, 4);
                alu = (t == 4) ? 5 : t;
            end
            sel = $urandom_range(0, 4);
            case (sel)
                0: t = int'($urandom_range(0, 4095)) - 2048;
                1: t = boundary[$urandom_range(0, 13)];
                2: t = int'($urandom);
                3: t = (int'($urandom_range(0, 8191)) - 4096) & ~1;
                default: t = (int'($urandom_range(0, 2097151)) - 1048576) & ~1;
            endcase
            imm = t;
            bl  = ($urandom_range(0, 19) == 0);
            ba  = $urandom_range(0, 1) ? 32'hFFFF_FFF8 : ($urandom & ~32'h3);
            issue(kind, alu, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  imm, bl, ba);
            if ($urandom_range(0, 3) == 0) sync();
        end
        rdy_rand = 0;
        out_ready = 1;
        sync();
        drain();
        @(negedge clk);
        check("final_count", {16'b0, count}, cnt_m);
        check("final_err", {31'b0, err}, {31'b0, err_m});
        check("final_err_code", {30'b0, err_code}, {30'b0, code_m});
        check("final_out_valid", {31'b0, out_valid}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have ports: in_valid  in  1  request valid; in_ready  out  1  request accepted when both high.
REQ-004 SHALL have ports: in_kind  in  3  0=lw 1=sw 2=R 3=beq 4=I-ALU 5=jal 6/7=illegal.
REQ-005 SHALL have ports: in_alu  in  3  ALU code 000 add, 001 sub, 010 and, 011 or, 101 slt; others illegal; used for kinds 2 and 4 only.
REQ-006 SHALL have ports: in_rd, in_rs1, in_rs2  in  5 each  register indices.
REQ-007 SHALL have ports: in_imm  in  32  signed byte immediate/offset.
REQ-008 SHALL have ports: base_load  in  1  pulse; base_addr  in  32  new write address.
REQ-009 SHALL have ports: out_valid  out  1; out_ready  in  1; out_instr  out  32  encoded word; out_addr  out  32  instruction-memory byte address.
REQ-010 SHALL have ports: err  out  1  sticky error; err_code  out  2  first error cause; count  out  16  emitted instructions.

Function
REQ-011 SHALL encode RV32I words: lw {imm[11:0],rs1,010,rd,0000011}; sw {imm[11:5],rs2,rs1,010,imm[4:0],0100011}; beq {imm[12],imm[10:5],rs2,rs1,000,imm[4:1],imm[11],1100011}; jal {imm[20],imm[10:1],imm[11],imm[19:12],rd,1101111}.
REQ-012 SHALL encode R {f7,rs2,rs1,f3,rd,0110011} and I {imm[11:0],rs1,f3,rd,0010011}; f3: add/sub 000, slt 010, or 110, and 111; f7=0100000 for sub, else 0.
REQ-013 SHALL flag a request illegal when: kind 6/7 (code 01); bad ALU code, or sub with kind 4 (code 10); imm out of range (code 11): lw/sw/I outside [-2048,2047], beq outside [-4096,4094] or odd, jal outside [-1048576,1048574] or odd.
REQ-014 SHALL drive in_ready = !out_valid | out_ready (single output register, full throughput).
REQ-015 SHALL, on legal accept, load out_instr/out_addr and set out_valid at the next edge (latency 1).
REQ-016 SHALL hold out_instr, out_addr, out_valid stable while out_valid & !out_ready.
REQ-017 SHALL clear out_valid after a handshake with no new legal accept in the same cycle.
REQ-018 SHALL complete the handshake of an illegal request without emitting an instruction, set err, and latch err_code only if err was 0.
REQ-019 SHALL keep a write pointer: each legal accept uses the pointer as out_addr, then advances it by 4, wrapping modulo 2^32.
REQ-020 SHALL, on base_load, set the pointer to base_addr; a legal accept in the same cycle uses base_addr and leaves the pointer at base_addr+4.
REQ-021 SHALL increment count on each legal accept, saturating at 0xFFFF.
REQ-022 SHALL ignore in_* fields when in_valid is low.

Reset
REQ-023 SHALL, on rst_n low, immediately clear out_valid, out_instr, out_addr, pointer, err, err_code and count to 0, discarding any held word; in_ready is 1 after reset.

Structure
REQ-024 SHALL take opcodes, kind codes, ALU codes, funct3/funct7 values and err_code values from shared package riscv_pkg, common with the instruction decoder.
REQ-025 SHALL place field packing and range checking in combinational sub-module instr_pack (outputs word, illegal, cause); sequencing, pointer and counters stay in instr_encoder.

Verification
REQ-026 SHALL check: after reset, R add rd=3 rs1=1 rs2=2 -> out_instr 0x002081B3, out_addr 0x0, count 1.
REQ-027 SHALL check: R sub rd=5 rs1=6 rs2=7 then lw rd=2 rs1=1 imm=-4 back-to-back -> 0x407302B3 at 0x0, then 0xFFC0A103 at 0x4.
REQ-028 SHALL check: base_load base_addr=0x100 with beq rs1=1 rs2=2 imm=8 in the same cycle -> 0x00208463 at 0x100; next jal rd=1 imm=2048 -> 0x001000EF at 0x104.
REQ-029 SHALL check: I add imm=2048 -> no out_valid, err=1, err_code=11; then I sub -> err_code stays 11.
REQ-030 SHALL check: out_ready low for 5 cycles with out_valid high -> out_* stable, in_ready=0; a queued request is then accepted in the cycle out_ready rises.
REQ-031 SHALL check: rst_n pulsed low while out_valid=1 -> out_valid=0, count=0, err=0, and the next word is placed at 0x0.
